// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : MEM/WB pipeline register with load-data extension.
// Optional retired-instruction counter enabled by MEM_WB_INSTRET_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [XLEN-1:0]       ReadDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            Funct3M,
  output logic                  ValidW,
  output logic [XLEN-1:0]       ALUResultW,
  output logic [XLEN-1:0]       ReadDataW,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [31:0]           InstRetW
);

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_ext;
  logic                  w_load_en;

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       alu_q, alu_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [XLEN-1:0]       pc4_q, pc4_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  regwr_q, regwr_d;
  logic [1:0]            rsrc_q, rsrc_d;

  always_comb begin
    w_byte = ReadDataM[7:0];
    case (ALUResultM[1:0])
      2'd1:    w_byte = ReadDataM[15:8];
      2'd2:    w_byte = ReadDataM[23:16];
      2'd3:    w_byte = ReadDataM[31:24];
      default: w_byte = ReadDataM[7:0];
    endcase
    w_half = ALUResultM[1] ? ReadDataM[31:16] : ReadDataM[15:0];

    case (Funct3M)
      c_LB:    w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_LBU:   w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
      c_LH:    w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
      c_LHU:   w_load_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_ext = ReadDataM;
    endcase
  end

  assign w_load_en = !FlushW && !StallW;

  // Priority: flush (bubble) over stall (hold) over normal load.
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc4_d   = pc4_q;
    rd_d    = rd_q;
    regwr_d = regwr_q;
    rsrc_d  = rsrc_q;
    if (FlushW) begin
      valid_d = 1'b0;
      alu_d   = '0;
      rdata_d = '0;
      pc4_d   = '0;
      rd_d    = '0;
      regwr_d = 1'b0;
      rsrc_d  = 2'b00;
    end else if (!StallW) begin
      valid_d = ValidM;
      alu_d   = ALUResultM;
      rdata_d = w_load_ext;
      pc4_d   = PCPlus4M;
      rd_d    = RdM;
      regwr_d = RegWriteM && (RdM != '0);
      rsrc_d  = ResultSrcM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
      rsrc_q  <= 2'b00;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc4_q   <= pc4_d;
      rd_q    <= rd_d;
      regwr_q <= regwr_d;
      rsrc_q  <= rsrc_d;
    end
  end

  assign ValidW     = valid_q;
  assign ALUResultW = alu_q;
  assign ReadDataW  = rdata_q;
  assign PCPlus4W   = pc4_q;
  assign RdW        = rd_q;
  assign RegWriteW  = regwr_q;
  assign ResultSrcW = rsrc_q;

`ifdef MEM_WB_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  assign instret_d = (w_load_en && ValidM) ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= '0;
    else      instret_q <= instret_d;
  end

  assign InstRetW = instret_q;
`else
  logic w_unused_load_en;
  assign w_unused_load_en = w_load_en;
  assign InstRetW         = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors, a behavioural
// reference model and a per-cycle compare process.
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallW, FlushW, ValidM, RegWriteM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        ValidW, RegWriteW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, InstRetW;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW;

  int tests = 0;
  int fails = 0;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ValidW(ValidW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .InstRetW(InstRetW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference load extension expressed with shifts/masks and signed arithmetic.
  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [31:0] a,
                                        input logic [2:0] f);
    logic [31:0] v;
    int          sh;
    case (f)
      3'd0, 3'd4: begin
        sh = 8 * int'(a % 4);
        v  = (w >> sh) & 32'hFF;
        if (f == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        sh = 16 * int'((a / 2) % 2);
        v  = (w >> sh) & 32'hFFFF;
        if (f == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  logic        m_valid, m_regwr;
  logic [31:0] m_alu, m_rdata, m_pc4, m_cnt;
  logic [4:0]  m_rd;
  logic [1:0]  m_rsrc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 0; m_regwr = 0; m_alu = 0; m_rdata = 0; m_pc4 = 0;
      m_rd = 0; m_rsrc = 0; m_cnt = 0;
    end else if (FlushW) begin
      m_valid = 0; m_regwr = 0; m_alu = 0; m_rdata = 0; m_pc4 = 0;
      m_rd = 0; m_rsrc = 0;
    end else if (!StallW) begin
      m_valid = ValidM;
      m_regwr = RegWriteM && (RdM != 0);
      m_alu   = ALUResultM;
      m_rdata = m_ext(ReadDataM, ALUResultM, Funct3M);
      m_pc4   = PCPlus4M;
      m_rd    = RdM;
      m_rsrc  = ResultSrcM;
`ifdef MEM_WB_INSTRET_EN
      if (ValidM) m_cnt = m_cnt + 1;
`endif
    end
  end

  always @(negedge clk) begin
    chk("cyc ValidW", {31'd0, ValidW}, {31'd0, m_valid});
    chk("cyc RegWriteW", {31'd0, RegWriteW}, {31'd0, m_regwr});
    chk("cyc ALUResultW", ALUResultW, m_alu);
    chk("cyc ReadDataW", ReadDataW, m_rdata);
    chk("cyc PCPlus4W", PCPlus4W, m_pc4);
    chk("cyc RdW", {27'd0, RdW}, {27'd0, m_rd});
    chk("cyc ResultSrcW", {30'd0, ResultSrcW}, {30'd0, m_rsrc});
    chk("cyc InstRetW", InstRetW, m_cnt);
  end

  task automatic drv(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                     input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                     input logic [1:0] rs, input logic [2:0] f3);
    ValidM = v; ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc4;
    RdM = rd; RegWriteM = rw; ResultSrcM = rs; Funct3M = f3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] byte_exp [4];

  initial begin
    byte_exp[0] = 32'h00000001; byte_exp[1] = 32'h0000007F;
    byte_exp[2] = 32'hFFFFFFFF; byte_exp[3] = 32'hFFFFFF80;
    rst = 0; StallW = 0; FlushW = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1;
    drv(1, 32'h1234, 32'h5678, 32'h9ABC, 5'd9, 1, 2'b10, 3'b010);
    step(); step();
    chk("pre-reset ValidW", {31'd0, ValidW}, 32'd1);
    // asynchronous reset in the middle of a cycle
    #2 rst = 0;
    #1;
    chk("async rst ValidW", {31'd0, ValidW}, 32'd0);
    chk("async rst ALUResultW", ALUResultW, 32'd0);
    chk("async rst ReadDataW", ReadDataW, 32'd0);
    chk("async rst PCPlus4W", PCPlus4W, 32'd0);
    chk("async rst RdW", {27'd0, RdW}, 32'd0);
    chk("async rst RegWriteW", {31'd0, RegWriteW}, 32'd0);
    #1 rst = 1;
    drv(1, 32'd5, 32'd10, 32'd15, 5'd3, 1, 2'b01, 3'b010);
    step();
    chk("post-rst ALUResultW", ALUResultW, 32'd5);
    chk("post-rst ReadDataW", ReadDataW, 32'd10);
    chk("post-rst PCPlus4W", PCPlus4W, 32'd15);
    chk("post-rst ResultSrcW", {30'd0, ResultSrcW}, 32'd1);

    for (int o = 0; o < 4; o++) begin
      drv(1, 32'h1000 + o, 32'h80FF7F01, 32'h44, 5'd4, 1, 2'b01, 3'b000);
      step();
      chk($sformatf("LB off%0d", o), ReadDataW, byte_exp[o]);
    end
    drv(1, 32'h1003, 32'h80FF7F01, 32'h48, 5'd4, 1, 2'b01, 3'b100);
    step(); chk("LBU off3", ReadDataW, 32'h00000080);

    drv(1, 32'h2000, 32'h80017FFE, 32'h4C, 5'd5, 1, 2'b01, 3'b001);
    step(); chk("LH lo", ReadDataW, 32'h00007FFE);
    drv(1, 32'h2002, 32'h80017FFE, 32'h50, 5'd5, 1, 2'b01, 3'b001);
    step(); chk("LH hi", ReadDataW, 32'hFFFF8001);
    drv(1, 32'h2003, 32'h80017FFE, 32'h54, 5'd5, 1, 2'b01, 3'b001);
    step(); chk("LH hi odd", ReadDataW, 32'hFFFF8001);
    drv(1, 32'h2002, 32'h80017FFE, 32'h58, 5'd5, 1, 2'b01, 3'b101);
    step(); chk("LHU hi", ReadDataW, 32'h00008001);
    drv(1, 32'h2003, 32'h80017FFE, 32'h5C, 5'd5, 1, 2'b01, 3'b010);
    step(); chk("LW off3", ReadDataW, 32'h80017FFE);
    drv(1, 32'h2001, 32'h80017FFE, 32'h60, 5'd5, 1, 2'b00, 3'b111);
    step(); chk("f3=111 raw", ReadDataW, 32'h80017FFE);

    drv(1, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd7, 1, 2'b00, 3'b010);
    step();
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h100 + i, 32'h200 + i, 32'h300 + i, 5'd12 + 5'(i), 0, 2'b10, 3'b000);
      step();
      chk("stall RdW", {27'd0, RdW}, 32'd7);
      chk("stall RegWriteW", {31'd0, RegWriteW}, 32'd1);
      chk("stall ALUResultW", ALUResultW, 32'hAAAA);
      chk("stall ReadDataW", ReadDataW, 32'hBBBB);
    end
    FlushW = 1;
    step();
    chk("flush ValidW", {31'd0, ValidW}, 32'd0);
    chk("flush RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("flush RdW", {27'd0, RdW}, 32'd0);
    StallW = 0; FlushW = 0;
    drv(1, 32'h10, 32'h20, 32'h30, 5'd0, 1, 2'b00, 3'b010);
    step();
    chk("x0 RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("x0 ValidW", {31'd0, ValidW}, 32'd1);

    // Retirement count: 10 valid loads, 2 stalls, 1 flush, 1 invalid slot.
    #2 rst = 0;
    #2 rst = 1;
    for (int i = 0; i < 10; i++) begin
      drv(1, 32'(i), 32'(i), 32'(i), 5'd1, 1, 2'b00, 3'b010);
      step();
    end
    StallW = 1; step(); step(); StallW = 0;
    FlushW = 1; step(); FlushW = 0;
    ValidM = 0; step();
`ifdef MEM_WB_INSTRET_EN
    chk("instret count", InstRetW, 32'd10);
`else
    chk("instret tied", InstRetW, 32'd0);
`endif
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
